// File: rtl/clz_pkg.sv
// clz_pkg: shared constants, sizing helpers and the pipeline slot type for
// the clz_norm_pipe leading-bit counter.
//
// The slot type is sized for the widest legal configuration (256-bit data,
// 9-bit count). Narrower instances zero-fill the unused upper bits, which
// synthesis removes as constant.
package clz_pkg;

  localparam int unsigned MAX_W     = 256;
  localparam int unsigned MAX_CNT_W = 9;

  // Ceiling log2. Valid for 1..2^31.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned log2w(input int unsigned data_w);
    return clog2(data_w);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned data_w);
    return clog2(data_w) + 1;
  endfunction

  // Number of register groups for a given stage packing.
  function automatic int unsigned ngrp(input int unsigned data_w,
                                       input int unsigned spr);
    return (clog2(data_w) + spr - 1) / spr;
  endfunction

  // One pipeline slot.
  //   valid : slot holds a sample
  //   mode  : 0 = leading zeros, 1 = leading ones
  //   cnt   : partial leading-bit count
  //   word  : working search word (mode-1 samples stored inverted)
  //   data  : full-width data (normalised progressively when enabled)
  typedef struct packed {
    logic                 valid;
    logic                 mode;
    logic [MAX_CNT_W-1:0] cnt;
    logic [MAX_W-1:0]     word;
    logic [MAX_W-1:0]     data;
  } slot_t;

endpackage

// File: rtl/clz_norm_pipe_step.sv
// clz_step: one combinational binary-search step of the leading-zero search.
//
// Parameters
//   DATA_W : data width (power of two, 4..256)
//   STEP   : search step k; examines a 2^k-bit half window
// Ports
//   word     in   working word, active window left-aligned
//   cnt      in   partial count
//   data     in   full-width data
//   word_nxt out  working word after this step
//   cnt_nxt  out  partial count after this step
//   data_nxt out  data after this step (shifted when CLZ_NORM_OUT_EN)
//
// Macro CLZ_NORM_OUT_EN: when defined, data is shifted left by 2^k whenever
// this step adds 2^k to the count; otherwise data passes through untouched.
module clz_step
  import clz_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned STEP   = 0
) (
  input  logic [DATA_W-1:0]      word,
  input  logic [clog2(DATA_W):0] cnt,
  input  logic [DATA_W-1:0]      data,
  output logic [DATA_W-1:0]      word_nxt,
  output logic [clog2(DATA_W):0] cnt_nxt,
  output logic [DATA_W-1:0]      data_nxt
);

  localparam int unsigned CNT_W = cnt_w(DATA_W);
  localparam int unsigned HALF  = 1 << STEP;

  logic              hit;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] data_s;
  logic [CNT_W-1:0]  cnt_s;

  // The active window is kept left-aligned: "keep the lower half" becomes a
  // left shift by the half width, so every step examines the top HALF bits.
  always_comb begin
    hit    = (word[DATA_W-1 -: HALF] == '0);
    word_s = hit ? (word << HALF) : word;
    cnt_s  = hit ? (cnt + CNT_W'(HALF)) : cnt;
`ifdef CLZ_NORM_OUT_EN
    data_s = hit ? (data << HALF) : data;
`else
    data_s = data;
`endif
  end

  if (STEP == 0) begin : g_last
    // Final remaining bit: a zero here means the word had no terminating bit.
    logic last;
    assign last     = ~word_s[DATA_W-1];
    assign word_nxt = word_s;
    assign cnt_nxt  = cnt_s + CNT_W'(last);
`ifdef CLZ_NORM_OUT_EN
    assign data_nxt = last ? (data_s << 1) : data_s;
`else
    assign data_nxt = data_s;
`endif
  end else begin : g_mid
    assign word_nxt = word_s;
    assign cnt_nxt  = cnt_s;
    assign data_nxt = data_s;
  end

endmodule

// File: rtl/clz_norm_pipe.sv
// clz_norm_pipe: pipelined leading-zero / leading-one counter with optional
// left normalisation and valid/ready backpressure.
//
// Parameters
//   DATA_W         : input word width (power of two, 4..256)
//   STAGES_PER_REG : search steps between pipeline registers (1..LOG2W)
//   Latency = 1 + ceil(LOG2W / STAGES_PER_REG) cycles.
// Ports
//   i_CLK   in   clock, rising edge
//   i_RSTn  in   asynchronous active-low reset
//   i_VALID in   input word valid
//   o_READY out  input accepted this cycle when i_VALID is high
//   i_MODE  in   0 = count leading zeros, 1 = count leading ones
//   i_DATA  in   input word
//   o_VALID out  output valid
//   i_READY in   downstream accepts output
//   o_CNT   out  leading-bit count, 0..DATA_W
//   o_ZERO  out  count equals DATA_W (no terminating bit)
//   o_DATA  out  normalised word (CLZ_NORM_OUT_EN) or delayed input word
//
// Macro CLZ_NORM_OUT_EN: defined -> o_DATA = i_DATA << o_CNT, zero-filled;
// undefined -> o_DATA = i_DATA delayed by the pipeline latency.
module clz_norm_pipe
  import clz_pkg::*;
#(
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned STAGES_PER_REG = 1
) (
  input  logic                   i_CLK,
  input  logic                   i_RSTn,
  input  logic                   i_VALID,
  output logic                   o_READY,
  input  logic                   i_MODE,
  input  logic [DATA_W-1:0]      i_DATA,
  output logic                   o_VALID,
  input  logic                   i_READY,
  output logic [clog2(DATA_W):0] o_CNT,
  output logic                   o_ZERO,
  output logic [DATA_W-1:0]      o_DATA
);

  localparam int unsigned LOG2W = log2w(DATA_W);
  localparam int unsigned CNT_W = cnt_w(DATA_W);
  localparam int unsigned NGRP  = ngrp(DATA_W, STAGES_PER_REG);

  // pipe[0] is the input register, pipe[NGRP] the output register.
  slot_t pipe    [NGRP+1];
  slot_t cap;
  slot_t grp_nxt [NGRP];

  logic adv;

  logic [DATA_W-1:0] step_word     [LOG2W];
  logic [CNT_W-1:0]  step_cnt      [LOG2W];
  logic [DATA_W-1:0] step_data     [LOG2W];
  logic [DATA_W-1:0] step_word_nxt [LOG2W];
  logic [CNT_W-1:0]  step_cnt_nxt  [LOG2W];
  logic [DATA_W-1:0] step_data_nxt [LOG2W];

  // Whole pipeline moves in lockstep; bubbles are carried, not squeezed.
  assign adv     = ~pipe[NGRP].valid | i_READY;
  assign o_READY = adv;

  // Mode-1 words are inverted here so a single zero-search serves both modes.
  always_comb begin
    cap                    = '0;
    cap.valid              = i_VALID;
    cap.mode               = i_MODE;
    cap.word[DATA_W-1:0]   = i_MODE ? ~i_DATA : i_DATA;
    cap.data[DATA_W-1:0]   = i_DATA;
  end

  // Step j performs search step k = LOG2W-1-j. The first step of each group
  // reads that group's register; the others chain combinationally.
  for (genvar j = 0; j < LOG2W; j++) begin : g_step
    if (j % STAGES_PER_REG == 0) begin : g_head
      assign step_word[j] = pipe[j / STAGES_PER_REG].word[DATA_W-1:0];
      assign step_cnt[j]  = pipe[j / STAGES_PER_REG].cnt[CNT_W-1:0];
      assign step_data[j] = pipe[j / STAGES_PER_REG].data[DATA_W-1:0];
    end else begin : g_chain
      assign step_word[j] = step_word_nxt[j-1];
      assign step_cnt[j]  = step_cnt_nxt[j-1];
      assign step_data[j] = step_data_nxt[j-1];
    end

    clz_step #(
      .DATA_W (DATA_W),
      .STEP   (LOG2W - 1 - j)
    ) u_step (
      .word     (step_word[j]),
      .cnt      (step_cnt[j]),
      .data     (step_data[j]),
      .word_nxt (step_word_nxt[j]),
      .cnt_nxt  (step_cnt_nxt[j]),
      .data_nxt (step_data_nxt[j])
    );
  end

  // Register g+1 captures the last step of group g.
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    localparam int unsigned LAST =
      ((g + 1) * STAGES_PER_REG < LOG2W) ? (g + 1) * STAGES_PER_REG - 1
                                         : LOG2W - 1;
    assign grp_nxt[g] = {pipe[g].valid,
                         pipe[g].mode,
                         MAX_CNT_W'(step_cnt_nxt[LAST]),
                         MAX_W'(step_word_nxt[LAST]),
                         MAX_W'(step_data_nxt[LAST])};
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int unsigned i = 0; i <= NGRP; i++) pipe[i] <= '0;
    end else if (adv) begin
      pipe[0] <= cap;
      for (int unsigned g = 0; g < NGRP; g++) pipe[g+1] <= grp_nxt[g];
    end
  end

  assign o_VALID = pipe[NGRP].valid;
  assign o_CNT   = pipe[NGRP].cnt[CNT_W-1:0];
  assign o_ZERO  = (o_CNT == CNT_W'(DATA_W));
  assign o_DATA  = pipe[NGRP].data[DATA_W-1:0];

  // Upper slot bits (beyond DATA_W) and the final working word are never
  // consumed; fold them into a dead signal.
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned i = 0; i <= NGRP; i++) unused_bits = unused_bits ^ (^pipe[i]);
  end

endmodule

// File: tb/tb_clz_norm_pipe.sv
// tb_clz_norm_pipe: self-checking bench for clz_norm_pipe. Two instances:
// DATA_W=128/STAGES_PER_REG=1 (latency 8) and DATA_W=32/STAGES_PER_REG=2
// (latency 4). A queue-based reference model predicts count, zero flag,
// output data and latency for every accepted word.
module tb_clz_norm_pipe;

  localparam int unsigned LAT128 = 8;
  localparam int unsigned LAT32  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         v128, m128, r128;
  logic [127:0] d128;
  logic         o_v128, o_rdy128, o_z128;
  logic [7:0]   o_c128;
  logic [127:0] o_d128;

  logic         v32, m32, r32;
  logic [31:0]  d32;
  logic         o_v32, o_rdy32, o_z32;
  logic [5:0]   o_c32;
  logic [31:0]  o_d32;

  clz_norm_pipe #(.DATA_W(128), .STAGES_PER_REG(1)) u_dut128 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(v128), .o_READY(o_rdy128),
    .i_MODE(m128), .i_DATA(d128), .o_VALID(o_v128), .i_READY(r128),
    .o_CNT(o_c128), .o_ZERO(o_z128), .o_DATA(o_d128)
  );

  clz_norm_pipe #(.DATA_W(32), .STAGES_PER_REG(2)) u_dut32 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(v32), .o_READY(o_rdy32),
    .i_MODE(m32), .i_DATA(d32), .o_VALID(o_v32), .i_READY(r32),
    .o_CNT(o_c32), .o_ZERO(o_z32), .o_DATA(o_d32)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: count of leading bits equal to the mode bit within w bits.
  function automatic int unsigned ref_cnt(input logic [255:0] d, input bit m,
                                          input int unsigned w);
    int unsigned n;
    n = 0;
    for (int i = int'(w) - 1; i >= 0; i--) begin
      if (d[i] != m) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [255:0] ref_data(input logic [255:0] d,
                                            input int unsigned n,
                                            input int unsigned w);
    logic [255:0] mask;
    mask = (256'd1 << w) - 256'd1;
`ifdef CLZ_NORM_OUT_EN
    return (d << n) & mask;
`else
    return d & mask;
`endif
  endfunction

  function automatic logic [127:0] rnd_word(input bit m);
    logic [127:0] x;
    x = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 128);
    return m ? ~x : x;
  endfunction

  typedef struct {
    int unsigned  cnt;
    logic [255:0] data;
    int unsigned  acc;
    int unsigned  st;
  } exp_t;

  exp_t        q128[$];
  exp_t        q32[$];
  exp_t        e128, e32, n128, n32;
  bit          seen128 = 1'b0, seen32 = 1'b0;
  int unsigned cyc = 0, stalls = 0;
  logic        adv128, adv32;

  // Compare process: outputs are stable here, half a cycle from the edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q128.delete();
      q32.delete();
      seen128 = 1'b0;
      seen32  = 1'b0;
      chk("rst_out128", {o_v128, o_c128, o_z128, o_d128}, '0);
      chk("rst_out32", {o_v32, o_c32, o_z32, o_d32}, '0);
    end else begin
      adv128 = !o_v128 || r128;
      adv32  = !o_v32 || r32;
      chk("ready128", o_rdy128, adv128);
      chk("ready32", o_rdy32, adv32);

      if (o_v128) begin
        if (q128.size() == 0) begin
          chk("spurious_valid128", o_v128, 0);
        end else begin
          e128 = q128[0];
          chk("cnt128", o_c128, e128.cnt);
          chk("zero128", o_z128, e128.cnt == 128);
          chk("data128", o_d128, e128.data);
          if (!seen128) chk("lat128", cyc - e128.acc, LAT128 + stalls - e128.st);
          seen128 = 1'b1;
          if (r128) begin
            void'(q128.pop_front());
            seen128 = 1'b0;
          end
        end
      end
      if (v128 && adv128) begin
        n128.cnt  = ref_cnt({128'd0, d128}, m128, 128);
        n128.data = ref_data({128'd0, d128}, n128.cnt, 128);
        n128.acc  = cyc;
        n128.st   = stalls;
        q128.push_back(n128);
      end
      if (!adv128) stalls++;

      if (o_v32) begin
        if (q32.size() == 0) begin
          chk("spurious_valid32", o_v32, 0);
        end else begin
          e32 = q32[0];
          chk("cnt32", o_c32, e32.cnt);
          chk("zero32", o_z32, e32.cnt == 32);
          chk("data32", o_d32, e32.data);
          if (!seen32) chk("lat32", cyc - e32.acc, LAT32);
          seen32 = 1'b1;
          if (r32) begin
            void'(q32.pop_front());
            seen32 = 1'b0;
          end
        end
      end
      if (v32 && adv32) begin
        n32.cnt  = ref_cnt({224'd0, d32}, m32, 32);
        n32.data = ref_data({224'd0, d32}, n32.cnt, 32);
        n32.acc  = cyc;
        n32.st   = 0;
        q32.push_back(n32);
      end
    end
  end

  // Offer one word until accepted (bounded).
  task automatic send(input logic [127:0] d, input bit m);
    bit          acc;
    int unsigned tries;
    acc   = 1'b0;
    tries = 0;
    v128 = 1'b1;
    d128 = d;
    m128 = m;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = o_rdy128;
      @(posedge clk);
      #1;
      tries++;
    end
    v128 = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  // 32-bit instance: one directed word, then a free-running random stream.
  initial begin
    v32 = 1'b0;
    m32 = 1'b0;
    d32 = '0;
    r32 = 1'b1;
    wait (rst_n);
    @(posedge clk);
    #1;
    v32 = 1'b1;
    d32 = 32'h0001_0000;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    repeat (LAT32) @(negedge clk);
    chk("d32_valid", o_v32, 1);
    chk("d32_cnt15", o_c32, 15);
    forever begin
      @(posedge clk);
      #1;
      v32 = 1'($urandom % 2);
      m32 = 1'($urandom % 2);
      d32 = 32'($urandom >> $urandom_range(0, 32));
      if (m32) d32 = ~d32;
    end
  end

  logic [127:0] words [20];

  initial begin
    bit          acc;
    int unsigned idx, cs;
    v128 = 1'b0;
    m128 = 1'b0;
    d128 = '0;
    r128 = 1'b1;

    // Model pins against hand-derived values.
    chk("pin_one", ref_cnt(256'h1, 0, 128), 127);
    chk("pin_zero", ref_cnt(256'h0, 0, 128), 128);
    chk("pin_ones", ref_cnt({128'd0, {128{1'b1}}}, 1, 128), 128);
    chk("pin_fff0", ref_cnt({128'd0, 16'hFFF0, 112'd0}, 1, 128), 12);
    chk("pin_32", ref_cnt(256'h0001_0000, 0, 32), 15);
`ifdef CLZ_NORM_OUT_EN
    chk("pin_norm_one", ref_data(256'h1, 127, 128), {128'd0, 1'b1, 127'd0});
    chk("pin_norm_fff0", ref_data({128'd0, 16'hFFF0, 112'd0}, 12, 128), '0);
`endif

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word, exact latency, literal expectations.
    v128 = 1'b1;
    m128 = 1'b0;
    d128 = 128'h1;
    @(posedge clk);
    #1;
    v128 = 1'b0;
    repeat (LAT128) @(negedge clk);
    chk("dir_valid", o_v128, 1);
    chk("dir_cnt127", o_c128, 127);
    chk("dir_zero0", o_z128, 0);
`ifdef CLZ_NORM_OUT_EN
    chk("dir_norm", o_d128, {128'd0, 1'b1, 127'd0});
`endif
    @(posedge clk);
    #1;

    // Boundary words.
    send('0, 1'b0);
    send('1, 1'b1);
    send({16'hFFF0, 112'd0}, 1'b1);
    send({1'b1, 127'd0}, 1'b0);
    send({1'b0, {127{1'b1}}}, 1'b1);
    repeat (12) @(posedge clk);
    #1;

    // 20-word stream, alternating modes, downstream stalled cycles 10-14.
    for (int i = 0; i < 20; i++) words[i] = rnd_word(1'(i % 2));
    idx = 0;
    cs  = 0;
    while (idx < 20 && cs < 200) begin
      v128 = 1'b1;
      d128 = words[idx];
      m128 = 1'(idx % 2);
      r128 = !(cs >= 10 && cs <= 14);
      @(negedge clk);
      acc = o_rdy128;
      if (cs == 12) chk("stall_ready0", o_rdy128, 0);
      @(posedge clk);
      #1;
      if (acc) idx++;
      cs++;
    end
    v128 = 1'b0;
    r128 = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      v128 = ($urandom % 4) != 0;
      r128 = ($urandom % 4) != 0;
      m128 = 1'($urandom % 2);
      d128 = rnd_word(m128);
      @(posedge clk);
      #1;
    end
    v128 = 1'b0;
    r128 = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Reset with five samples in flight.
    for (int i = 0; i < 5; i++) begin
      v128 = 1'b1;
      m128 = 1'(i % 2);
      d128 = rnd_word(m128);
      @(posedge clk);
      #1;
    end
    v128  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("flush_no_valid", o_v128, 0);
    end
    @(posedge clk);
    #1;
    send(128'hF, 1'b0);
    repeat (LAT128) @(negedge clk);
    chk("post_rst_valid", o_v128, 1);
    chk("post_rst_cnt", o_c128, 124);

    repeat (20) @(posedge clk);
    #1;
    v128 = 1'b0;
    chk("q128_drained", q128.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
